// File: rtl/neopx_pkg.sv
// neopx_pkg: shared definitions for the NeoPixel frame streamer.
//   PX_W             pixel word width (32)
//   LATCH_CYCLES_DEF default strip latch/reset low time in clocks
//   state_t          frame streamer FSM states
//   scale_px()       per-byte (byte*brightness)>>8 scaling
package neopx_pkg;

  localparam int unsigned PX_W             = 32;
  localparam int unsigned LATCH_CYCLES_DEF = 6600;

  // ST_SCALE is only reachable when the brightness pipeline stage is built.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_LOAD,
    ST_SCALE,
    ST_SEND,
    ST_DRAIN,
    ST_LATCH
  } state_t;

  function automatic logic [PX_W-1:0] scale_px(input logic [PX_W-1:0] px,
                                               input logic [7:0]      br);
    logic [15:0]     prod;
    logic [PX_W-1:0] res;
    res = '0;
    for (int unsigned i = 0; i < PX_W / 8; i++) begin
      prod           = 16'(px[i*8 +: 8]) * 16'(br);
      res[i*8 +: 8]  = prod[15:8];
    end
    return res;
  endfunction

endpackage

// File: rtl/neopx_pixel_ram.sv
// neopx_pixel_ram: simple dual-port frame RAM, 2^ADDR_W x PX_W.
//   axis_aclk  clock
//   wr_en/wr_addr/wr_data  write port
//   rd_en/rd_addr          synchronous read request
//   rd_data                read word, valid the cycle after rd_en (read-first)
// Contents are never reset.
module neopx_pixel_ram
  import neopx_pkg::*;
#(
  parameter int unsigned ADDR_W = 8
) (
  input  logic              axis_aclk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [PX_W-1:0]   wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [PX_W-1:0]   rd_data
);

  logic [PX_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge axis_aclk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/neopx_frame_streamer.sv
// neopx_frame_streamer: streams one stored frame of pixel words over AXI-Stream,
// waits for the serialiser to go idle, then holds the strip latch time.
//   axis_aclk, axis_aresetn   clock, async active-low reset
//   wr_en/wr_addr/wr_data     pixel RAM write port (accepted in every state)
//   num_px, start             frame length (sampled on accepted start), request
//   brightness                global scale, only used with NEOPX_BRIGHTNESS_EN
//   busy, frame_done          frame in progress, end-of-latch pulse
//   m_axis_data/valid/ready   AXI-Stream master
// Optional build macro: NEOPX_BRIGHTNESS_EN (per-byte brightness scaling plus an
// extra pipeline stage between LOAD and SEND).
module neopx_frame_streamer
  import neopx_pkg::*;
#(
  parameter int unsigned ADDR_W       = 8,
  parameter int unsigned LATCH_CYCLES = LATCH_CYCLES_DEF
) (
  input  logic              axis_aclk,
  input  logic              axis_aresetn,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [PX_W-1:0]   wr_data,
  input  logic [ADDR_W:0]   num_px,
  input  logic [7:0]        brightness,
  input  logic              start,
  output logic              busy,
  output logic              frame_done,
  output logic [PX_W-1:0]   m_axis_data,
  output logic              m_axis_valid,
  input  logic              m_axis_ready
);

  localparam int unsigned   CNT_W    = (LATCH_CYCLES > 1) ? $clog2(LATCH_CYCLES) : 1;
  localparam logic [ADDR_W:0] CAPACITY = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] IDX_ONE  = (ADDR_W+1)'(1);

  state_t            state, state_nxt;
  logic [ADDR_W:0]   px_idx, px_cnt;
  logic [CNT_W-1:0]  latch_cnt;
  logic [PX_W-1:0]   ram_q;
  logic              rd_en;
  logic              handshake, last_word, latch_done, accept_start;

  assign handshake    = m_axis_valid && m_axis_ready;
  assign last_word    = (px_idx == (px_cnt - IDX_ONE));
  assign latch_done   = (latch_cnt == CNT_W'(LATCH_CYCLES - 1));
  assign accept_start = start && (num_px != '0);

  neopx_pixel_ram #(
    .ADDR_W (ADDR_W)
  ) u_ram (
    .axis_aclk (axis_aclk),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .rd_en     (rd_en),
    .rd_addr   (px_idx[ADDR_W-1:0]),
    .rd_data   (ram_q)
  );

  always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
    if (!axis_aresetn) state <= ST_IDLE;
    else               state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    rd_en     = 1'b0;
    busy      = (state != ST_IDLE);
    case (state)
      ST_IDLE:  if (accept_start) state_nxt = ST_READ;
      ST_READ: begin
        rd_en     = 1'b1;
        state_nxt = ST_LOAD;
      end
`ifdef NEOPX_BRIGHTNESS_EN
      ST_LOAD:  state_nxt = ST_SCALE;
`else
      ST_LOAD:  state_nxt = ST_SEND;
`endif
      ST_SCALE: state_nxt = ST_SEND;
      ST_SEND:  if (handshake) state_nxt = last_word ? ST_DRAIN : ST_READ;
      ST_DRAIN: if (m_axis_ready) state_nxt = ST_LATCH;
      ST_LATCH: if (latch_done) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

`ifdef NEOPX_BRIGHTNESS_EN
  logic [PX_W-1:0] scaled_q;
`else
  logic unused_brightness;
  assign unused_brightness = ^brightness;
`endif

  always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
    if (!axis_aresetn) begin
      px_idx       <= '0;
      px_cnt       <= '0;
      latch_cnt    <= '0;
      m_axis_data  <= '0;
      m_axis_valid <= 1'b0;
      frame_done   <= 1'b0;
`ifdef NEOPX_BRIGHTNESS_EN
      scaled_q     <= '0;
`endif
    end else begin
      frame_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept_start) begin
            px_cnt <= (num_px > CAPACITY) ? CAPACITY : num_px;
            px_idx <= '0;
          end
        end
`ifdef NEOPX_BRIGHTNESS_EN
        ST_LOAD:  scaled_q <= scale_px(ram_q, brightness);
        ST_SCALE: begin
          m_axis_data  <= scaled_q;
          m_axis_valid <= 1'b1;
        end
`else
        ST_LOAD: begin
          m_axis_data  <= ram_q;
          m_axis_valid <= 1'b1;
        end
`endif
        ST_SEND: begin
          if (handshake) begin
            m_axis_valid <= 1'b0;
            px_idx       <= px_idx + IDX_ONE;
          end
        end
        ST_DRAIN: if (m_axis_ready) latch_cnt <= '0;
        ST_LATCH: begin
          latch_cnt <= latch_cnt + CNT_W'(1);
          if (latch_done) frame_done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_neopx_frame_streamer.sv
module tb_neopx_frame_streamer;
  localparam int ADDR_W = 4;
  localparam int DEPTH  = 16;
  localparam int LC     = 20;
`ifdef NEOPX_BRIGHTNESS_EN
  localparam int          FIRST_LAT  = 3;
  localparam logic [31:0] EXP_BRIGHT = 32'h7F402000;
`else
  localparam int          FIRST_LAT  = 2;
  localparam logic [31:0] EXP_BRIGHT = 32'hFF804000;
`endif

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              wr_en = 1'b0;
  logic [ADDR_W-1:0] wr_addr = '0;
  logic [31:0]       wr_data = '0;
  logic [ADDR_W:0]   num_px = '0;
  logic [7:0]        brightness = 8'hFF;
  logic              start = 1'b0;
  logic              busy, frame_done, m_axis_valid;
  logic [31:0]       m_axis_data;
  logic              m_axis_ready = 1'b1;

  neopx_frame_streamer #(
    .ADDR_W       (ADDR_W),
    .LATCH_CYCLES (LC)
  ) dut (
    .axis_aclk    (clk),
    .axis_aresetn (rst_n),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .num_px       (num_px),
    .brightness   (brightness),
    .start        (start),
    .busy         (busy),
    .frame_done   (frame_done),
    .m_axis_data  (m_axis_data),
    .m_axis_valid (m_axis_valid),
    .m_axis_ready (m_axis_ready)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          passed = 0;
  logic [31:0] hs_q[$];
  logic [31:0] exp_q[$];
  logic [31:0] mem_model[DEPTH];
  int          done_cnt = 0;
  int          stab_err = 0;
  int          cyc = 0;
  int          last_hs_edge = -1;
  bit          prev_pending = 0;
  logic [31:0] prev_data = '0;

  // Monitor: handshakes, frame_done pulses and AXIS hold rule, sampled at the edge.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rst_n) begin
      prev_pending = 0;
    end else begin
      if (prev_pending && (!m_axis_valid || m_axis_data !== prev_data)) stab_err++;
      if (m_axis_valid && m_axis_ready) begin
        hs_q.push_back(m_axis_data);
        last_hs_edge = cyc;
      end
      if (frame_done) done_cnt++;
      prev_pending = m_axis_valid && !m_axis_ready;
      prev_data    = m_axis_data;
    end
  end

  function automatic logic [31:0] exp_word(input logic [31:0] w);
`ifdef NEOPX_BRIGHTNESS_EN
    logic [31:0] r;
    r[31:24] = 8'((32'(w[31:24]) * 32'(brightness)) >> 8);
    r[23:16] = 8'((32'(w[23:16]) * 32'(brightness)) >> 8);
    r[15:8]  = 8'((32'(w[15:8])  * 32'(brightness)) >> 8);
    r[7:0]   = 8'((32'(w[7:0])   * 32'(brightness)) >> 8);
    return r;
`else
    return w;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_px(input int a, input logic [31:0] d);
    wr_en = 1'b1; wr_addr = ADDR_W'(a); wr_data = d;
    mem_model[a] = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic pulse_start(input int n, input bit push);
    if (push)
      for (int i = 0; i < n && i < DEPTH; i++) exp_q.push_back(exp_word(mem_model[i]));
    num_px = (ADDR_W+1)'(n);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(output bit ok, output int e);
    ok = 0; e = -1;
    for (int i = 0; i < 3000; i++) begin
      tick();
      if (frame_done) begin ok = 1; e = cyc - 1; break; end
    end
  endtask

  task automatic wait_hs(input int n, output bit ok);
    ok = 0;
    for (int i = 0; i < 200; i++) begin
      if (hs_q.size() >= n) begin ok = 1; break; end
      tick();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    checks++; if (m_axis_valid !== 1'b0) $display("FAIL reset_valid got=%b exp=0", m_axis_valid); else passed++;
    checks++; if (m_axis_data !== 32'h0) $display("FAIL reset_data got=%h exp=0", m_axis_data); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy); else passed++;
    checks++; if (frame_done !== 1'b0) $display("FAIL reset_done got=%b exp=0", frame_done); else passed++;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    bit ok; int e;
    write_px(0, 32'hAA000000); write_px(1, 32'h00BB0000); write_px(2, 32'h0000CC00);
    hs_q.delete(); exp_q.delete(); done_cnt = 0; stab_err = 0; m_axis_ready = 1'b1;
    pulse_start(3, 1);
    checks++; if (busy !== 1'b1) $display("FAIL basic_busy got=%b exp=1", busy); else passed++;
    checks++; if (m_axis_valid !== 1'b0) $display("FAIL basic_valid_n got=%b exp=0", m_axis_valid); else passed++;
    for (int k = 1; k < FIRST_LAT; k++) begin
      tick();
      checks++; if (m_axis_valid !== 1'b0) $display("FAIL basic_valid_early k=%0d got=%b exp=0", k, m_axis_valid); else passed++;
    end
    tick();
    checks++; if (m_axis_valid !== 1'b1) $display("FAIL basic_first_valid got=%b exp=1", m_axis_valid); else passed++;
    checks++; if (m_axis_data !== exp_q[0]) $display("FAIL basic_first_data got=%h exp=%h", m_axis_data, exp_q[0]); else passed++;
    wait_done(ok, e);
    checks++; if (!ok) $display("FAIL basic_done_timeout got=0 exp=1"); else passed++;
    checks++; if (e !== last_hs_edge + 1 + LC) $display("FAIL basic_done_edge got=%0d exp=%0d", e, last_hs_edge + 1 + LC); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL basic_busy_end got=%b exp=0", busy); else passed++;
    tick();
    checks++; if (hs_q.size() !== exp_q.size()) $display("FAIL basic_count got=%0d exp=%0d", hs_q.size(), exp_q.size()); else passed++;
    while (exp_q.size() > 0 && hs_q.size() > 0) begin
      logic [31:0] g, x;
      g = hs_q.pop_front(); x = exp_q.pop_front();
      checks++; if (g !== x) $display("FAIL basic_word got=%h exp=%h", g, x); else passed++;
    end
    checks++; if (done_cnt !== 1) $display("FAIL basic_done_cnt got=%0d exp=1", done_cnt); else passed++;
    checks++; if (stab_err !== 0) $display("FAIL basic_axis_hold got=%0d exp=0", stab_err); else passed++;
  endtask

  task automatic test_backpressure();
    bit ok; int e;
    hs_q.delete(); exp_q.delete(); done_cnt = 0; stab_err = 0; m_axis_ready = 1'b1;
    pulse_start(3, 1);
    wait_hs(1, ok);
    checks++; if (!ok) $display("FAIL bp_first_hs_timeout got=0 exp=1"); else passed++;
    m_axis_ready = 1'b0;
    repeat (10) tick();
    checks++; if (m_axis_valid !== 1'b1) $display("FAIL bp_valid_held got=%b exp=1", m_axis_valid); else passed++;
    checks++; if (m_axis_data !== exp_word(32'h00BB0000)) $display("FAIL bp_data_held got=%h exp=%h", m_axis_data, exp_word(32'h00BB0000)); else passed++;
    checks++; if (hs_q.size() !== 1) $display("FAIL bp_no_extra_hs got=%0d exp=1", hs_q.size()); else passed++;
    m_axis_ready = 1'b1;
    wait_done(ok, e);
    checks++; if (!ok) $display("FAIL bp_done_timeout got=0 exp=1"); else passed++;
    tick();
    checks++; if (hs_q.size() !== exp_q.size()) $display("FAIL bp_count got=%0d exp=%0d", hs_q.size(), exp_q.size()); else passed++;
    while (exp_q.size() > 0 && hs_q.size() > 0) begin
      logic [31:0] g, x;
      g = hs_q.pop_front(); x = exp_q.pop_front();
      checks++; if (g !== x) $display("FAIL bp_word got=%h exp=%h", g, x); else passed++;
    end
    checks++; if (stab_err !== 0) $display("FAIL bp_axis_hold got=%0d exp=0", stab_err); else passed++;
    checks++; if (done_cnt !== 1) $display("FAIL bp_done_cnt got=%0d exp=1", done_cnt); else passed++;
  endtask

  task automatic test_start_ignored();
    bit ok; int e; bit any_valid;
    hs_q.delete(); exp_q.delete(); done_cnt = 0;
    pulse_start(3, 1);
    repeat (3) tick();
    pulse_start(3, 0);
    wait_done(ok, e);
    checks++; if (!ok) $display("FAIL ign_done_timeout got=0 exp=1"); else passed++;
    repeat (30) tick();
    checks++; if (hs_q.size() !== 3) $display("FAIL ign_count got=%0d exp=3", hs_q.size()); else passed++;
    while (exp_q.size() > 0 && hs_q.size() > 0) begin
      logic [31:0] g, x;
      g = hs_q.pop_front(); x = exp_q.pop_front();
      checks++; if (g !== x) $display("FAIL ign_word got=%h exp=%h", g, x); else passed++;
    end
    checks++; if (done_cnt !== 1) $display("FAIL ign_done_cnt got=%0d exp=1", done_cnt); else passed++;
    hs_q.delete();
    pulse_start(0, 0);
    checks++; if (busy !== 1'b0) $display("FAIL zero_busy got=%b exp=0", busy); else passed++;
    any_valid = 0;
    repeat (6) begin tick(); if (m_axis_valid || busy) any_valid = 1; end
    checks++; if (any_valid !== 1'b0) $display("FAIL zero_activity got=%b exp=0", any_valid); else passed++;
    checks++; if (hs_q.size() !== 0) $display("FAIL zero_hs got=%0d exp=0", hs_q.size()); else passed++;
  endtask

  task automatic test_full();
    bit ok; int e;
    for (int i = 0; i < DEPTH; i++) write_px(i, 32'hC0DE0000 | (i * 32'h1111));
    hs_q.delete(); exp_q.delete(); done_cnt = 0; stab_err = 0;
    pulse_start(DEPTH + 5, 1);
    wait_done(ok, e);
    checks++; if (!ok) $display("FAIL full_done_timeout got=0 exp=1"); else passed++;
    repeat (10) tick();
    checks++; if (hs_q.size() !== DEPTH) $display("FAIL full_count got=%0d exp=%0d", hs_q.size(), DEPTH); else passed++;
    while (exp_q.size() > 0 && hs_q.size() > 0) begin
      logic [31:0] g, x;
      g = hs_q.pop_front(); x = exp_q.pop_front();
      checks++; if (g !== x) $display("FAIL full_word got=%h exp=%h", g, x); else passed++;
    end
    checks++; if (done_cnt !== 1) $display("FAIL full_done_cnt got=%0d exp=1", done_cnt); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL full_busy_end got=%b exp=0", busy); else passed++;
  endtask

  task automatic test_reset_abort();
    bit ok; int e;
    hs_q.delete(); exp_q.delete(); done_cnt = 0;
    pulse_start(3, 0);
    wait_hs(2, ok);
    checks++; if (!ok) $display("FAIL abort_hs_timeout got=0 exp=1"); else passed++;
    for (int i = 0; i < 10 && !m_axis_valid; i++) tick();
    #2 rst_n = 1'b0;
    #1;
    checks++; if (m_axis_valid !== 1'b0) $display("FAIL abort_valid got=%b exp=0", m_axis_valid); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL abort_busy got=%b exp=0", busy); else passed++;
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (LC + 10) tick();
    checks++; if (done_cnt !== 0) $display("FAIL abort_no_done got=%0d exp=0", done_cnt); else passed++;
    checks++; if (hs_q.size() !== 2) $display("FAIL abort_hs_count got=%0d exp=2", hs_q.size()); else passed++;
    hs_q.delete();
    pulse_start(3, 1);
    wait_done(ok, e);
    checks++; if (!ok) $display("FAIL replay_done_timeout got=0 exp=1"); else passed++;
    tick();
    checks++; if (hs_q.size() !== exp_q.size()) $display("FAIL replay_count got=%0d exp=%0d", hs_q.size(), exp_q.size()); else passed++;
    while (exp_q.size() > 0 && hs_q.size() > 0) begin
      logic [31:0] g, x;
      g = hs_q.pop_front(); x = exp_q.pop_front();
      checks++; if (g !== x) $display("FAIL replay_word got=%h exp=%h", g, x); else passed++;
    end
    checks++; if (done_cnt !== 1) $display("FAIL replay_done_cnt got=%0d exp=1", done_cnt); else passed++;
  endtask

  task automatic test_brightness();
    bit ok; int e;
    brightness = 8'h80;
    write_px(0, 32'hFF804000);
    hs_q.delete(); exp_q.delete(); done_cnt = 0;
    pulse_start(1, 0);
    wait_done(ok, e);
    checks++; if (!ok) $display("FAIL bright_done_timeout got=0 exp=1"); else passed++;
    tick();
    checks++; if (hs_q.size() !== 1) $display("FAIL bright_count got=%0d exp=1", hs_q.size()); else passed++;
    if (hs_q.size() > 0) begin
      checks++; if (hs_q[0] !== EXP_BRIGHT) $display("FAIL bright_word got=%h exp=%h", hs_q[0], EXP_BRIGHT); else passed++;
    end
  endtask

  initial begin
    tick();
    test_reset();
    test_basic();
    test_backpressure();
    test_start_ignored();
    test_full();
    test_reset_abort();
    test_brightness();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=timeout exp=finish");
    $fatal(1);
  end

endmodule
